// File: rtl/cinit_gen_pkg.sv
// Shared constants and types for the Gold-sequence initialiser generator.
package cinit_gen_pkg;

    localparam int unsigned CINIT_W      = 28;
    localparam int unsigned SHIFT        = 10;
    localparam int unsigned L_FIRST      = 5;
    localparam int unsigned L_SECOND     = 6;
    localparam int unsigned SYM_PER_SLOT = 7;

    localparam int unsigned DEF_WIDTH    = 18;
    localparam int unsigned DEF_WIDTH_A  = 8;
    localparam int unsigned DEF_WIDTH_B  = 9;

    typedef enum logic {
        SYM_L5 = 1'b0,
        SYM_L6 = 1'b1
    } sym_e;

endpackage

// File: rtl/cinit_gen_nrs_mult.sv
// Combinational unsigned multiplier, zero-extended to the product width.
module nrs_mult #(
    parameter int unsigned WIDTH_A = 8,
    parameter int unsigned WIDTH_B = 9,
    parameter int unsigned WIDTH   = 18
) (
    input  logic [WIDTH_A-1:0] a,
    input  logic [WIDTH_B-1:0] b,
    output logic [WIDTH-1:0]   p
);

    assign p = WIDTH'(a) * WIDTH'(b);

endmodule

// File: rtl/cinit_gen.sv
// Generates cinit for symbol pairs (l=5, l=6) of a slot, one result per run cycle.
module cinit_gen
    import cinit_gen_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned WIDTH_A = DEF_WIDTH_A,
    parameter int unsigned WIDTH_B = DEF_WIDTH_B
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [WIDTH_B-1:0] N_cell_ID,
    input  logic [4:0]         slot,
    output logic [CINIT_W-1:0] cinit,
    output logic               valid
);

    sym_e               state_q;
    sym_e               state_d;
    logic [WIDTH_A-1:0] a_term;
    logic [WIDTH-1:0]   prod;
    logic [WIDTH-1:0]   sum;
    logic [CINIT_W-1:0] cinit_d;
    logic               valid_d;
    int unsigned        l_val;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= SYM_L5;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (run) begin
            state_d = (state_q == SYM_L5) ? SYM_L6 : SYM_L5;
        end
    end

    // A = 7*(slot+1) + l + 1 uses the symbol index before it toggles
    assign l_val  = (state_q == SYM_L5) ? L_FIRST : L_SECOND;
    assign a_term = WIDTH_A'(SYM_PER_SLOT * (32'(slot) + 32'd1) + l_val + 32'd1);

    nrs_mult #(
        .WIDTH_A (WIDTH_A),
        .WIDTH_B (WIDTH_B),
        .WIDTH   (WIDTH)
    ) u_mult (
        .a (a_term),
        .b (N_cell_ID),
        .p (prod)
    );

    // A*(2N+1) = 2*(A*N) + A
    assign sum = (prod << 1) + WIDTH'(a_term);

    always_comb begin
        cinit_d = cinit;
        valid_d = 1'b0;
        if (run) begin
            cinit_d = (CINIT_W'(sum) << SHIFT) + CINIT_W'({N_cell_ID, 1'b1});
            valid_d = (state_q == SYM_L5);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cinit <= '0;
            valid <= 1'b0;
        end else begin
            cinit <= cinit_d;
            valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_cinit_gen.sv
// Directed scoreboard bench for cinit_gen.
module tb_cinit_gen;

    logic        clk;
    logic        rst;
    logic        run;
    logic [8:0]  N_cell_ID;
    logic [4:0]  slot;
    logic [27:0] cinit;
    logic        valid;

    typedef struct {
        logic [27:0] c;
        logic        v;
    } exp_t;

    exp_t        sb[$];
    int          total;
    int          bad;
    int          m_l;
    logic [27:0] m_c;
    logic        m_v;

    cinit_gen dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .N_cell_ID (N_cell_ID),
        .slot      (slot),
        .cinit     (cinit),
        .valid     (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [27:0] calc(input int n, input int s, input int l);
        longint x;
        x = 64'd1024 * longint'(7 * (s + 1) + l + 1) * longint'(2 * n + 1) + longint'(2 * n + 1);
        return 28'(x);
    endfunction

    task automatic chk(input string tag, input logic [27:0] got, input logic [27:0] want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    // Drive one cycle, predict the registered result, then compare after the edge
    task automatic step(input string tag, input logic r_rst, input logic r_run,
                        input int n, input int s);
        exp_t e;
        rst       = r_rst;
        run       = r_run;
        N_cell_ID = 9'(n);
        slot      = 5'(s);
        if (!r_rst) begin
            m_l = 5;
            m_c = '0;
            m_v = 1'b0;
        end else if (r_run) begin
            m_c = calc(n, s, m_l);
            m_v = (m_l == 5);
            m_l = (m_l == 5) ? 6 : 5;
        end else begin
            m_v = 1'b0;
        end
        sb.push_back('{m_c, m_v});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_cinit"}, cinit, e.c);
            chk({tag, "_valid"}, 28'(valid), 28'(e.v));
        end
    endtask

    initial begin
        int slots[18];
        total = 0;
        bad   = 0;
        m_l   = 5;
        m_c   = '0;
        m_v   = 1'b0;
        foreach (slots[i]) slots[i] = (i < 10) ? i : i + 2;

        // reset dominates run
        for (int i = 0; i < 5; i++) step("rst_run", 1'b0, 1'b1, 100 + i, i);
        chk("rst_zero", cinit, 28'd0);

        // idle with varying cell IDs leaves outputs at zero
        for (int n = 0; n <= 504; n++) step("idle", 1'b1, 1'b0, n, n % 20);
        chk("idle_zero", cinit, 28'd0);

        // first pair, N=0 slot=0
        step("n0_l5", 1'b1, 1'b1, 0, 0);
        chk("n0_l5_const", cinit, 28'd13313);
        chk("n0_l5_valid", 28'(valid), 28'd1);
        step("n0_l6", 1'b1, 1'b1, 0, 0);
        chk("n0_l6_const", cinit, 28'd14337);
        chk("n0_l6_valid", 28'(valid), 28'd0);

        // largest legal value
        step("max_l5", 1'b1, 1'b1, 503, 19);
        step("max_l6", 1'b1, 1'b1, 503, 19);
        chk("max_const", cinit, 28'd151582703);

        // gap between the two halves of a pair; inputs wiggle while idle
        step("gap_l5", 1'b1, 1'b1, 77, 3);
        step("gap_idle0", 1'b1, 1'b0, 12, 8);
        step("gap_idle1", 1'b1, 1'b0, 400, 17);
        step("gap_idle2", 1'b1, 1'b0, 5, 0);
        step("gap_l6", 1'b1, 1'b1, 77, 3);
        chk("gap_l6_valid", 28'(valid), 28'd0);

        // reset after an l=5 run restarts at l=5
        step("mid_l5", 1'b1, 1'b1, 250, 6);
        step("mid_rst", 1'b0, 1'b0, 250, 6);
        step("mid_again", 1'b1, 1'b1, 250, 6);
        chk("mid_again_valid", 28'(valid), 28'd1);
        step("mid_l6", 1'b1, 1'b1, 250, 6);

        // out-of-range inputs follow the same formula
        step("oor_l5", 1'b1, 1'b1, 511, 31);
        step("oor_l6", 1'b1, 1'b1, 511, 31);
        step("oor_slot10", 1'b1, 1'b1, 509, 10);
        step("oor_slot11", 1'b1, 1'b1, 509, 11);

        // continuous back-to-back sweep
        for (int n = 0; n <= 504; n++) begin
            foreach (slots[i]) begin
                step("sweep_l5", 1'b1, 1'b1, n, slots[i]);
                step("sweep_l6", 1'b1, 1'b1, n, slots[i]);
            end
        end

        // hold after the sweep
        step("hold", 1'b1, 1'b0, 3, 3);
        chk("hold_const", cinit, calc(504, 19, 6));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
